// File: rtl/rv_pkg.sv
// Shared RV64 fetch definitions: architectural widths, the canonical NOP
// encoding and the {PC, instruction} record carried through the fetch FIFO.
package rv_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] RV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/rv_sync_fifo.sv
// Circular-buffer FIFO with occupancy counter; clear wins over push and pop,
// and the head is read straight from storage (no bypass of incoming data).
module rv_sync_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  input  logic                   i_clear,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_count != '0) && !i_clear;
  assign w_push = i_push && !i_clear && ((r_count != CW'(DEPTH)) || w_pop);

  // Storage carries no reset so it maps onto plain memory.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
endmodule

// File: rtl/rv_fetch_queue.sv
// Instruction-fetch front end: credit-limited request issue, in-order response
// tracking, wrong-path drop accounting on redirect, and a {PC, instr} FIFO.
module rv_fetch_queue
  import rv_pkg::*;
#(
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = 64'h0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            req_valid_o,
  input  logic            req_ready_i,
  output logic [XLEN-1:0] req_addr_o,
  input  logic            rsp_valid_i,
  input  logic [ILEN-1:0] rsp_data_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            err_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [OW-1:0]   r_outstanding;
  logic [OW-1:0]   r_drop_cnt;
  logic            r_err;

  logic [CW-1:0]   w_count;
  logic            w_empty;
  logic            w_full;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_entry;
  logic [31:0]     w_credit_sum;
  logic [31:0]     w_inflight_sum;
  logic            w_req_fire;
  logic            w_rsp_drop;
  logic            w_rsp_push;
  logic            w_rsp_spurious;
  logic            w_rsp_inflight;
  logic            w_fifo_push;
  logic            w_fifo_pop;
  logic            w_overflow;
  logic [XLEN-1:0] w_redirect_pc;

  // FIFO slots already promised to outstanding requests count against space.
  assign w_credit_sum   = 32'(w_count) + 32'(r_outstanding);
  assign w_inflight_sum = 32'(r_outstanding) + 32'(r_drop_cnt);
  assign req_valid_o    = (r_state == S_RUN) &&
                          (w_credit_sum < 32'(DEPTH)) &&
                          (w_inflight_sum < 32'(MAX_OUTSTANDING));
  assign req_addr_o     = r_fetch_pc;
  assign w_req_fire     = req_valid_o && req_ready_i;

  assign w_rsp_drop     = rsp_valid_i && (r_drop_cnt != '0);
  assign w_rsp_push     = rsp_valid_i && (r_drop_cnt == '0) && (r_outstanding != '0);
  assign w_rsp_spurious = rsp_valid_i && (r_drop_cnt == '0) && (r_outstanding == '0);
  assign w_rsp_inflight = w_rsp_drop || w_rsp_push;
  assign w_redirect_pc  = {redirect_pc_i[XLEN-1:2], 2'b00};

  assign w_fifo_push    = w_rsp_push && !redirect_i;
  assign w_fifo_pop     = instr_valid_o && instr_ready_i;
  assign w_overflow     = w_fifo_push && w_full && !w_fifo_pop;

  assign w_push_entry.pc    = r_rsp_pc;
  assign w_push_entry.instr = rsp_data_i;

  rv_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_fifo_push),
    .i_data  (w_push_entry),
    .i_pop   (w_fifo_pop),
    .i_clear (redirect_i),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_INIT;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_err         <= 1'b0;
    end else begin
      if (r_state == S_INIT) r_state <= S_RUN;
      if (w_rsp_spurious || w_overflow) r_err <= 1'b1;
      if (redirect_i) begin
        // Everything still in flight, including a request accepted right now,
        // belongs to the old path and must be swallowed when it returns.
        r_fetch_pc    <= w_redirect_pc;
        r_rsp_pc      <= w_redirect_pc;
        r_outstanding <= '0;
        r_drop_cnt    <= r_drop_cnt + r_outstanding + OW'(w_req_fire) - OW'(w_rsp_inflight);
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + 64'd4;
        if (w_rsp_push) r_rsp_pc   <= r_rsp_pc + 64'd4;
        r_outstanding <= r_outstanding + OW'(w_req_fire) - OW'(w_rsp_push);
        if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - OW'(1);
      end
    end
  end

  assign instr_valid_o = !w_empty;
  assign instr_o       = w_head.instr;
  assign pc_o          = w_head.pc;
  assign err_o         = r_err;
endmodule

// File: tb/tb_rv_fetch_queue.sv
// Bench for rv_fetch_queue: in-order memory model plus an epoch-tagged
// scoreboard of the correct-path instruction stream, with directed scenarios.
module tb_rv_fetch_queue;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        req_valid_o;
  logic        req_ready_i = 1'b0;
  logic [63:0] req_addr_o;
  logic        rsp_valid_i = 1'b0;
  logic [31:0] rsp_data_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [63:0] pc_o;
  logic        err_o;

  rv_fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(64'h0)) dut (
    .clk(clk), .rstn(rstn), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
    .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .pc_o(pc_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  int n_tests = 0;
  int n_fail  = 0;

  // memory side: every accepted request, tagged with the path epoch it was issued on
  logic [63:0] mq_addr[$];
  int          mq_epoch[$];
  // reference: correct-path instructions that should be sitting in the queue
  ent_t        ref_q[$];
  int          epoch = 0;
  logic [63:0] ref_fetch_pc = 64'h0;
  logic        ref_err = 1'b0;
  int          posedge_cnt = 0;
  int          p_ready = 100, p_rsp = 100, p_iready = 100;
  bit          last_fire;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: check outputs, drive inputs, advance model, run one cycle.
  task automatic step(input bit redir, input logic [63:0] rpc, input bit spurious);
    int   inflight_cur;
    bit   exp_rv;
    bit   fire;
    bit   pop;
    ent_t e;
    logic [63:0] a;
    int   ep;
    inflight_cur = 0;
    foreach (mq_epoch[i]) if (mq_epoch[i] == epoch) inflight_cur++;
    exp_rv = (posedge_cnt >= 1) && (ref_q.size() + inflight_cur < DEPTH) && (mq_addr.size() < MAXO);
    chk("req_valid", req_valid_o, exp_rv);
    if (exp_rv) chk("req_addr", req_addr_o, ref_fetch_pc);
    chk("instr_valid", instr_valid_o, ref_q.size() != 0);
    if (ref_q.size() != 0) begin
      chk("pc", pc_o, ref_q[0].pc);
      chk("instr", instr_o, ref_q[0].instr);
    end
    chk("err", err_o, ref_err);

    redirect_i    = redir;
    redirect_pc_i = rpc;
    req_ready_i   = ($urandom_range(99) < p_ready);
    instr_ready_i = ($urandom_range(99) < p_iready);
    if (spurious) begin
      rsp_valid_i = 1'b1;
      rsp_data_i  = $urandom;
    end else if (mq_addr.size() > 0 && $urandom_range(99) < p_rsp) begin
      rsp_valid_i = 1'b1;
      rsp_data_i  = mem_word(mq_addr[0]);
    end else begin
      rsp_valid_i = 1'b0;
      rsp_data_i  = $urandom;
    end

    fire = req_valid_o && req_ready_i;
    last_fire = fire;
    pop = !redir && (ref_q.size() != 0) && instr_ready_i;
    if (pop) begin
      e = ref_q.pop_front();
      $display("[TB] deliver pc=%h instr=%h", e.pc, e.instr);
    end
    if (rsp_valid_i) begin
      if (mq_addr.size() == 0) ref_err = 1'b1;
      else begin
        a  = mq_addr.pop_front();
        ep = mq_epoch.pop_front();
        if (!redir && ep == epoch) begin
          e.pc = a;
          e.instr = mem_word(a);
          ref_q.push_back(e);
        end
      end
    end
    if (fire) begin
      mq_addr.push_back(req_addr_o);
      mq_epoch.push_back(epoch);
    end
    if (redir) begin
      ref_q.delete();
      epoch++;
      ref_fetch_pc = {rpc[63:2], 2'b00};
    end else if (fire) begin
      ref_fetch_pc = ref_fetch_pc + 64'd4;
    end

    @(posedge clk);
    posedge_cnt++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_req_valid", req_valid_o, 1'b0);
    chk("rst_instr_valid", instr_valid_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    redirect_i = 1'b0; req_ready_i = 1'b0; rsp_valid_i = 1'b0; instr_ready_i = 1'b0;
    mq_addr.delete(); mq_epoch.delete(); ref_q.delete();
    epoch++;
    ref_fetch_pc = 64'h0;
    ref_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    posedge_cnt = 0;
  endtask

  initial begin
    int fire_step, valid_step, nvalid, nfire;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    posedge_cnt = 0;

    // reset release, zero-wait memory
    chk("init_no_req", req_valid_o, 1'b0);
    p_ready = 100; p_rsp = 100; p_iready = 100;
    fire_step = -1; valid_step = -1; nvalid = 0;
    for (int k = 0; k < 12; k++) begin
      if (instr_valid_o && valid_step < 0) valid_step = k;
      if (k >= 3 && instr_valid_o) nvalid++;
      step(1'b0, 64'h0, 1'b0);
      if (last_fire && fire_step < 0) fire_step = k;
    end
    chk("first_req_cycle", 64'(fire_step), 64'd1);
    chk("first_valid_latency", 64'(valid_step - fire_step), 64'd2);
    chk("throughput", 64'(nvalid), 64'd9);

    // backpressure from a fresh start
    do_reset();
    p_iready = 0; nfire = 0;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 64'h0, 1'b0);
      if (last_fire) nfire++;
    end
    chk("bp_accepted", 64'(nfire), 64'd4);
    chk("bp_req_dropped", req_valid_o, 1'b0);
    p_iready = 100;
    for (int k = 0; k < 8; k++) step(1'b0, 64'h0, 1'b0);

    // redirect with two requests outstanding
    p_rsp = 0;
    for (int k = 0; k < 20 && mq_addr.size() < 2; k++) step(1'b0, 64'h0, 1'b0);
    chk("two_outstanding", 64'(mq_addr.size()), 64'd2);
    step(1'b1, 64'h1003, 1'b0);
    chk("flush_empty", instr_valid_o, 1'b0);
    p_rsp = 100;
    for (int k = 0; k < 20 && !instr_valid_o; k++) step(1'b0, 64'h0, 1'b0);
    chk("redir_pc", pc_o, 64'h1000);
    chk("redir_instr", instr_o, mem_word(64'h1000));

    // redirect coincident with a handshake and a response
    p_ready = 0;
    for (int k = 0; k < 20 && mq_addr.size() != 0; k++) step(1'b0, 64'h0, 1'b0);
    p_ready = 100; p_rsp = 0;
    step(1'b0, 64'h0, 1'b0);
    chk("coinc_one_out", 64'(mq_addr.size()), 64'd1);
    chk("coinc_req_valid", req_valid_o, 1'b1);
    p_rsp = 100;
    step(1'b1, 64'h2000, 1'b0);
    for (int k = 0; k < 20 && !instr_valid_o; k++) step(1'b0, 64'h0, 1'b0);
    chk("coinc_pc", pc_o, 64'h2000);

    // randomized traffic with occasional redirects
    for (int k = 0; k < 400; k++) begin
      p_ready  = $urandom_range(30, 100);
      p_rsp    = $urandom_range(30, 100);
      p_iready = $urandom_range(20, 100);
      if ($urandom_range(99) < 5) step(1'b1, {$urandom, $urandom}, 1'b0);
      else step(1'b0, 64'h0, 1'b0);
    end

    // spurious response with nothing in flight
    p_ready = 100; p_rsp = 100; p_iready = 0;
    for (int k = 0; k < 4; k++) step(1'b0, 64'h0, 1'b0);
    p_ready = 0;
    for (int k = 0; k < 20 && mq_addr.size() != 0; k++) step(1'b0, 64'h0, 1'b0);
    chk("spur_idle", 64'(mq_addr.size()), 64'd0);
    chk("spur_pre_err", err_o, 1'b0);
    step(1'b0, 64'h0, 1'b1);
    chk("spur_err", err_o, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 64'h0, 1'b0);
    chk("spur_sticky", err_o, 1'b1);

    // address wrap, then asynchronous reset mid-stream
    p_ready = 100; p_rsp = 100; p_iready = 100;
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    chk("wrap_first", req_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, 64'h0, 1'b0);
    chk("wrap_next", req_addr_o, 64'h0);
    for (int k = 0; k < 5; k++) step(1'b0, 64'h0, 1'b0);
    do_reset();
    for (int k = 0; k < 10; k++) step(1'b0, 64'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
